// File: rtl/cam_pkg.sv
// cam_pkg: state encodings, fault codes and helpers shared by the camera power monitor.
package cam_pkg;
    localparam logic [1:0] ST_OFF        = 2'd0;
    localparam logic [1:0] ST_WAIT_PGOOD = 2'd1;
    localparam logic [1:0] ST_POWERED    = 2'd2;
    localparam logic [1:0] ST_FAULT      = 2'd3;

    typedef enum logic [1:0] {
        OFF        = ST_OFF,
        WAIT_PGOOD = ST_WAIT_PGOOD,
        POWERED    = ST_POWERED,
        FAULT      = ST_FAULT
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_BROWNOUT = 2'b10;
    localparam logic [1:0] FC_REGFAULT = 2'b11;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/cam_power_monitor_if.sv
// cam_power_monitor_if: host-side status bus of the camera power monitor.
//   status_clr       host -> monitor  one-cycle clear pulse
//   cam_ok           monitor -> host  camera powered and out of reset
//   cam_fault        monitor -> host  fault latched
//   cam_kill         monitor -> host  request to drop camera control
//   fault_code       monitor -> host  latched fault cause
//   pwr_cycle_count  monitor -> host  saturating power-up attempt count
interface cam_power_monitor_if;
    logic       status_clr;
    logic       cam_ok;
    logic       cam_fault;
    logic       cam_kill;
    logic [1:0] fault_code;
    logic [7:0] pwr_cycle_count;

    modport master (
        output status_clr,
        input  cam_ok, cam_fault, cam_kill, fault_code, pwr_cycle_count
    );

    modport slave (
        input  status_clr,
        output cam_ok, cam_fault, cam_kill, fault_code, pwr_cycle_count
    );
endinterface

// File: rtl/cam_input_debouncer.sv
// cam_input_debouncer: 2-flop synchronizer followed by a consecutive-cycle debouncer.
//   sclk_i    in   slow clock
//   reset_i   in   asynchronous active-high reset
//   async_i   in   raw board line
//   stable_o  out  debounced value, resets to 0
module cam_input_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd128
) (
    input  logic sclk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic stable_o
);
    logic [1:0]  sync_q, sync_d;
    logic        stable_q, stable_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge sclk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // cnt_q holds how many earlier consecutive cycles the synchronized value
    // already disagreed; any agreeing cycle restarts it from zero.
    always_comb begin
        sync_d   = {sync_q[0], async_i};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1)
                stable_d = sync_q[1];
            else
                cnt_d = cnt_q + 16'd1;
        end
    end

    assign stable_o = stable_q;
endmodule

// File: rtl/cam_power_monitor.sv
// cam_power_monitor: checks camera board power-good/fault against the sequencer drive and reports health.
//   sclk_i         in   slow oscillator clock
//   reset_i        in   asynchronous active-high reset
//   cam_pwr_en_i   in   sequencer power-enable drive
//   cam_reset_i    in   sequencer camera-reset drive, 1 = out of reset
//   cam_pgood_i    in   board power-good, asynchronous
//   cam_fault_n_i  in   board regulator fault, active-low, asynchronous
//   host           slave modport of the host status bus
module cam_power_monitor
    import cam_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd128,
    parameter logic [15:0] PGOOD_TIMEOUT   = 16'd2560
) (
    input  logic sclk_i,
    input  logic reset_i,
    input  logic cam_pwr_en_i,
    input  logic cam_reset_i,
    input  logic cam_pgood_i,
    input  logic cam_fault_n_i,
    cam_power_monitor_if.slave host
);
    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  count_q, count_d;
    logic        ok_q, ok_d;
    logic        fault_q, fault_d;
    logic        pgood_db, fault_db, inc;

    cam_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pgood_db (
        .sclk_i  (sclk_i),
        .reset_i (reset_i),
        .async_i (cam_pgood_i),
        .stable_o(pgood_db)
    );

    cam_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fault_db (
        .sclk_i  (sclk_i),
        .reset_i (reset_i),
        .async_i (~cam_fault_n_i),
        .stable_o(fault_db)
    );

    always_ff @(posedge sclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= OFF;
            timer_q <= '0;
            code_q  <= FC_NONE;
            count_q <= '0;
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            count_q <= count_d;
            ok_q    <= ok_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        inc     = 1'b0;
        case (state_q)
            OFF: begin
                if (cam_pwr_en_i) begin
                    state_d = WAIT_PGOOD;
                    timer_d = PGOOD_TIMEOUT;
                    inc     = 1'b1;
                end
            end
            WAIT_PGOOD: begin
                // pgood is checked before the expired timer so a power-good
                // accepted on the last allowed cycle still counts as success.
                if (fault_db) begin
                    state_d = FAULT;
                    code_d  = FC_REGFAULT;
                end else if (!cam_pwr_en_i) begin
                    state_d = OFF;
                end else if (pgood_db) begin
                    state_d = POWERED;
                end else if (timer_q == 16'd0) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            POWERED: begin
                if (fault_db) begin
                    state_d = FAULT;
                    code_d  = FC_REGFAULT;
                end else if (!cam_pwr_en_i) begin
                    state_d = OFF;
                end else if (!pgood_db) begin
                    state_d = FAULT;
                    code_d  = FC_BROWNOUT;
                end
            end
            FAULT: begin
                if (host.status_clr && !cam_pwr_en_i) begin
                    state_d = OFF;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = OFF;
        endcase
        // A clear landing on a power-up attempt leaves that attempt counted.
        count_d = host.status_clr ? {7'd0, inc} : (inc ? sat_inc(count_q) : count_q);
        ok_d    = (state_d == POWERED) && cam_reset_i;
        fault_d = (state_d == FAULT);
    end

    assign host.cam_ok          = ok_q;
    assign host.cam_fault       = fault_q;
    assign host.cam_kill        = fault_q;
    assign host.fault_code      = code_q;
    assign host.pwr_cycle_count = count_q;
endmodule

// File: tb/tb_cam_power_monitor.sv
// tb_cam_power_monitor: scoreboard-driven self-checking bench for cam_power_monitor.
module tb_cam_power_monitor;
    typedef struct {
        string      name;
        logic [12:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, cam_rst, pgood, fault_n;
    logic [12:0] obs;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    cam_power_monitor_if bus();

    cam_power_monitor #(.DEBOUNCE_CYCLES(16'd4), .PGOOD_TIMEOUT(16'd20)) dut (
        .sclk_i       (clk),
        .reset_i      (rst),
        .cam_pwr_en_i (en),
        .cam_reset_i  (cam_rst),
        .cam_pgood_i  (pgood),
        .cam_fault_n_i(fault_n),
        .host         (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.cam_ok, bus.cam_fault, bus.cam_kill, bus.fault_code, bus.pwr_cycle_count};

    function automatic logic [12:0] ev(input logic ok, input logic f, input logic [1:0] c, input logic [7:0] n);
        return {ok, f, f, c, n};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.status_clr = 1'b1;
        cyc(1);
        bus.status_clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b0; cam_rst = 1'b0; pgood = 1'b0; fault_n = 1'b1; bus.status_clr = 1'b0;
        sb.push_back('{"reset_held", ev(0, 0, 2'b00, 8'd0)});
        cyc(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        rst = 1'b0;
        sb.push_back('{"reset_released", ev(0, 0, 2'b00, 8'd0)});
        cyc(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_power_up();
        exp_t e;
        en = 1'b1;
        cyc(5);
        pgood = 1'b1;
        sb.push_back('{"powered_in_reset", ev(0, 0, 2'b00, 8'd1)});
        cyc(10);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        cam_rst = 1'b1;
        sb.push_back('{"cam_ok", ev(1, 0, 2'b00, 8'd1)});
        cyc(1);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_glitch();
        exp_t e;
        pgood = 1'b0;
        cyc(3);
        pgood = 1'b1;
        sb.push_back('{"glitch_3_ignored", ev(1, 0, 2'b00, 8'd1)});
        cyc(10);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        pgood = 1'b0;
        cyc(6);
        pgood = 1'b1;
        sb.push_back('{"brownout_6", ev(0, 1, 2'b10, 8'd1)});
        cyc(4);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_clear();
        exp_t e;
        pulse_clr();
        sb.push_back('{"clr_with_en_held", ev(0, 1, 2'b10, 8'd0)});
        cyc(2);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        en = 1'b0;
        sb.push_back('{"fault_held_no_clr", ev(0, 1, 2'b10, 8'd0)});
        cyc(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        pulse_clr();
        sb.push_back('{"clr_to_off", ev(0, 0, 2'b00, 8'd0)});
        cyc(2);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        pgood = 1'b0;
        cyc(12);
        en = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 100 && bus.cam_fault !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 21) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 21", n); end
        sb.push_back('{"timeout_code", ev(0, 1, 2'b01, 8'd1)});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        en = 1'b0;
        pulse_clr();
        cyc(2);
    endtask

    task automatic test_fault_priority();
        exp_t e;
        en = 1'b1;
        cyc(2);
        fault_n = 1'b0;
        cyc(6);
        en = 1'b0;
        sb.push_back('{"regfault_over_en_drop", ev(0, 1, 2'b11, 8'd1)});
        cyc(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        pulse_clr();
        sb.push_back('{"regfault_in_off_ignored", ev(0, 0, 2'b00, 8'd0)});
        cyc(6);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        fault_n = 1'b1;
        cyc(10);
    endtask

    task automatic test_pgood_race(input int lag, input logic [12:0] want, input string name);
        exp_t e;
        pgood = 1'b0;
        cyc(12);
        en = 1'b1;
        cyc(lag);
        pgood = 1'b1;
        sb.push_back('{name, want});
        cyc(12);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        en = 1'b0;
        cyc(2);
        pulse_clr();
        cyc(2);
    endtask

    task automatic test_saturation();
        exp_t e;
        pgood = 1'b0;
        cyc(12);
        for (int i = 0; i < 260; i++) begin
            en = 1'b1;
            cyc(1);
            en = 1'b0;
            cyc(1);
            if (i == 253) begin
                sb.push_back('{"count_254", ev(0, 0, 2'b00, 8'd254)});
                e = sb.pop_front(); checks++;
                if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
            end
        end
        sb.push_back('{"count_saturated", ev(0, 0, 2'b00, 8'd255)});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        en = 1'b1;
        bus.status_clr = 1'b1;
        sb.push_back('{"clr_with_increment", ev(0, 0, 2'b00, 8'd1)});
        cyc(1);
        bus.status_clr = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        en = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        pgood = 1'b1;
        en = 1'b1;
        sb.push_back('{"powered_before_reset", ev(1, 0, 2'b00, 8'd2)});
        cyc(15);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.push_back('{"async_reset_powered", ev(0, 0, 2'b00, 8'd0)});
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        rst = 1'b0;
        cyc(15);
        fault_n = 1'b0;
        sb.push_back('{"regfault_powered", ev(0, 1, 2'b11, 8'd1)});
        cyc(10);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.push_back('{"async_reset_fault", ev(0, 0, 2'b00, 8'd0)});
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        en = 1'b0;
        fault_n = 1'b1;
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch();
        test_clear();
        test_timeout();
        test_fault_priority();
        test_pgood_race(15, ev(1, 0, 2'b00, 8'd1), "pgood_wins_last_cycle");
        test_pgood_race(16, ev(0, 1, 2'b01, 8'd1), "pgood_one_cycle_late");
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
